// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit padded block, then streams W[0..63] over a valid/ready handshake.
// A 16-word sliding window produces W[t+16] while W[t] is being handed off.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_last
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WIN_N    = 16;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned LAST_IDX = 63;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   window_q [WIN_N];
    logic [WORD_W-1:0]   window_d [WIN_N];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   w_new;
    logic                blk_fire;
    logic                w_fire;
    logic                at_last;

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign blk_fire = (state_q == S_IDLE) && blk_valid;
    assign w_fire   = (state_q == S_RUN) && w_ready;
    assign at_last  = (idx_q == IDX_W'(LAST_IDX));

    // Next schedule word, wrapping mod 2^32.
    assign w_new = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: load on block handshake, return after the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (blk_fire) state_d = S_RUN;
            S_RUN:   if (w_fire && at_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and registers only.
    always_comb begin
        blk_ready = (state_q == S_IDLE);
        w_valid   = (state_q == S_RUN);
        w_data    = window_q[0];
        w_idx     = idx_q;
        w_last    = (state_q == S_RUN) && at_last;
    end

    // Window / index next values: parallel load, or shift with the new word appended.
    always_comb begin
        for (int i = 0; i < WIN_N; i++) begin
            window_d[i] = window_q[i];
        end
        idx_d = idx_q;
        if (blk_fire) begin
            for (int i = 0; i < WIN_N; i++) begin
                window_d[i] = blk_data[WORD_W*(WIN_N-1-i) +: WORD_W];
            end
            idx_d = '0;
        end else if (w_fire) begin
            for (int i = 0; i < WIN_N-1; i++) begin
                window_d[i] = window_q[i+1];
            end
            window_d[WIN_N-1] = w_new;
            idx_d = at_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Window and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_N; i++) begin
                window_q[i] <= '0;
            end
            idx_q <= '0;
        end else begin
            for (int i = 0; i < WIN_N; i++) begin
                window_q[i] <= window_d[i];
            end
            idx_q <= idx_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: golden schedule model plus hand-derived words.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    logic [31:0] ref_w [64];

    logic [511:0] blk_abc;
    logic [511:0] blk_ones;
    logic [511:0] blk_zero;
    logic [511:0] blk_b;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Golden SHA-256 schedule into exp_w.
    task automatic build_exp(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    // Present a block and complete its handshake; optionally leave blk_valid high.
    task automatic load(input logic [511:0] b, input bit keep_valid);
        int guard = 0;
        while (!blk_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        chk("load_ready", 64'(blk_ready), 64'd1);
        blk_valid = 1'b1;
        blk_data  = b;
        @(posedge clk); #1;
        if (!keep_valid) blk_valid = 1'b0;
    endtask

    // Consume 64 words; mode 0 = w_ready always high, mode 1 = stalls.
    task automatic drain(input int mode);
        int got = 0;
        int cyc = 0;
        int hold15 = 10;
        int hold63 = 10;
        bit rdy;
        bit prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic [5:0]  prev_i = '0;
        while (got < 64 && cyc < 2000) begin
            if (mode == 1 && w_idx == 6'd15 && hold15 > 0) begin
                rdy = 1'b0; hold15--;
            end else if (mode == 1 && w_idx == 6'd63 && hold63 > 0) begin
                rdy = 1'b0; hold63--;
            end else if (mode == 1) begin
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                rdy = 1'b1;
            end
            w_ready = rdy;
            chk("w_valid", 64'(w_valid), 64'd1);
            if (prev_stall) begin
                chk("hold_data", 64'(w_data), 64'(prev_d));
                chk("hold_idx", 64'(w_idx), 64'(prev_i));
            end
            if (rdy) begin
                chk("w_idx", 64'(w_idx), 64'(got));
                chk("w_data", 64'(w_data), 64'(exp_w[got]));
                chk("w_last", 64'(w_last), 64'(got == 63));
                if (mode == 0 && got == 63) chk("last_cycle", 64'(cyc), 64'd63);
                got_w[got] = w_data;
                got++;
            end else begin
                chk("w_last_stall", 64'(w_last), 64'(w_idx == 6'd63));
            end
            prev_stall = !rdy;
            prev_d = w_data;
            prev_i = w_idx;
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_count", 64'(got), 64'd64);
        w_ready = 1'b0;
        chk("end_blk_ready", 64'(blk_ready), 64'd1);
        chk("end_w_valid", 64'(w_valid), 64'd0);
    endtask

    initial begin
        blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
        blk_ones = {512{1'b1}};
        blk_zero = '0;
        for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'h9E3779B9 * (i + 1);

        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
        #22;
        chk("rst_blk_ready", 64'(blk_ready), 64'd1);
        chk("rst_w_valid", 64'(w_valid), 64'd0);
        chk("rst_w_data", 64'(w_data), 64'd0);
        chk("rst_w_idx", 64'(w_idx), 64'd0);
        chk("rst_w_last", 64'(w_last), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc" block, full rate.
        build_exp(blk_abc);
        load(blk_abc, 1'b0);
        drain(0);
        chk("abc_w0", 64'(got_w[0]), 64'h61626380);
        chk("abc_w15", 64'(got_w[15]), 64'h00000018);
        chk("abc_w16", 64'(got_w[16]), 64'h61626380);
        chk("abc_w17", 64'(got_w[17]), 64'h000F0000);
        for (int t = 0; t < 64; t++) ref_w[t] = got_w[t];

        // Same block with stalls; sequence must match the unstalled run.
        @(posedge clk); #1;
        load(blk_abc, 1'b0);
        drain(1);
        for (int t = 0; t < 64; t++) chk("stall_seq", 64'(got_w[t]), 64'(ref_w[t]));

        // Wrap-around arithmetic.
        build_exp(blk_ones);
        load(blk_ones, 1'b0);
        drain(0);
        build_exp(blk_zero);
        load(blk_zero, 1'b0);
        drain(0);
        for (int t = 0; t < 64; t++) chk("zero_word", 64'(got_w[t]), 64'd0);

        // Back-to-back with blk_valid held high; data changes during RUN ignored.
        @(posedge clk); #1;
        build_exp(blk_abc);
        load(blk_abc, 1'b1);
        blk_data = blk_b;
        drain(0);
        // The next edge is the second block's handshake.
        build_exp(blk_b);
        chk("b2b_accept", 64'(blk_ready && blk_valid), 64'd1);
        @(posedge clk); #1;
        blk_valid = 1'b0;
        blk_data  = blk_ones;
        chk("b2b_run", 64'(w_valid), 64'd1);
        drain(0);

        // Asynchronous reset at w_idx = 37.
        @(posedge clk); #1;
        build_exp(blk_abc);
        load(blk_abc, 1'b0);
        w_ready = 1'b1;
        repeat (37) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_idx", 64'(w_idx), 64'd37);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_valid", 64'(w_valid), 64'd0);
        chk("mid_rst_blk_ready", 64'(blk_ready), 64'd1);
        chk("mid_rst_w_idx", 64'(w_idx), 64'd0);
        chk("mid_rst_w_data", 64'(w_data), 64'd0);
        chk("mid_rst_w_last", 64'(w_last), 64'd0);
        w_ready = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load(blk_abc, 1'b0);
        chk("post_rst_w0", 64'(w_data), 64'h61626380);
        drain(0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
